// File: rtl/div16x8_seq_pkg.sv
// Shared definitions for the sequential 16/8 restoring divider: widths, state codes and
// the quotient reported on divide-by-zero.
package div16x8_seq_pkg;

    localparam int unsigned DEF_N   = 16;
    localparam int unsigned DEF_D   = 8;
    localparam int unsigned STATE_W = 3;

    localparam logic [15:0] DZ_QUOTIENT = 16'hFFFF;

    // Codes are visible on state_out and decoded by the seven-segment controller.
    typedef enum logic [STATE_W-1:0] {
        IDLE  = 3'd0,
        CALC  = 3'd1,
        DONE  = 3'd2,
        DZERO = 3'd3
    } state_e;

endpackage

// File: rtl/div16x8_seq_control.sv
// Divider sequencer: start/done handshake, iteration counter and status flags.
module div16x8_seq_control
    import div16x8_seq_pkg::*;
#(
    parameter int unsigned N = DEF_N
) (
    input  logic               clk,
    input  logic               reset_a,
    input  logic               start_i,
    input  logic               divisor_zero_i,
    output logic               load_o,
    output logic               dz_load_o,
    output logic               calc_o,
    output logic               last_o,
    output logic               done_flag_o,
    output logic               dz_flag_o,
    output logic [STATE_W-1:0] state_out_o
);

    localparam int unsigned CntW = $clog2(N);

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (reset_a) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        load_o    = 1'b0;
        dz_load_o = 1'b0;
        last_o    = 1'b0;
        case (state_q)
            IDLE, DONE, DZERO: begin
                if (start_i) begin
                    if (divisor_zero_i) begin
                        state_d   = DZERO;
                        dz_load_o = 1'b1;
                    end else begin
                        state_d = CALC;
                        load_o  = 1'b1;
                        cnt_d   = '0;
                    end
                end
            end
            CALC: begin
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntW'(N - 1)) begin
                    state_d = DONE;
                    last_o  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign calc_o      = (state_q == CALC);
    assign done_flag_o = (state_q == DONE) || (state_q == DZERO);
    assign dz_flag_o   = (state_q == DZERO);
    assign state_out_o = state_q;

endmodule

// File: rtl/div16x8_seq.sv
// Sequential restoring divider, one quotient bit per clock. Datapath lives here; the
// sequencing lives in div16x8_seq_control.
module div16x8_seq
    import div16x8_seq_pkg::*;
#(
    parameter int unsigned N = DEF_N,
    parameter int unsigned D = DEF_D
) (
    input  logic               clk,
    input  logic               reset_a,
    input  logic               start,
    input  logic [N-1:0]       dividend,
    input  logic [D-1:0]       divisor,
    output logic [N-1:0]       quotient_out,
    output logic [D-1:0]       remainder_out,
    output logic               done_flag,
    output logic               dz_flag,
    output logic [STATE_W-1:0] state_out
);

    logic load, dz_load, calc, last;

    logic [D-1:0] r_q, r_d;
    logic [N-1:0] q_q, q_d;
    logic [D-1:0] divisor_q, divisor_d;
    logic [N-1:0] quotient_q, quotient_d;
    logic [D-1:0] remainder_q, remainder_d;

    logic [D:0]   t;
    logic         ge;
    logic [D-1:0] diff;
    logic [D-1:0] r_step;
    logic [N-1:0] q_step;

    div16x8_seq_control #(
        .N(N)
    ) u_control (
        .clk           (clk),
        .reset_a       (reset_a),
        .start_i       (start),
        .divisor_zero_i(divisor == '0),
        .load_o        (load),
        .dz_load_o     (dz_load),
        .calc_o        (calc),
        .last_o        (last),
        .done_flag_o   (done_flag),
        .dz_flag_o     (dz_flag),
        .state_out_o   (state_out)
    );

    // T carries one extra bit so divisors above 2^(D-1) compare correctly; when T >= divisor
    // the difference always fits in D bits, so the subtract can be done at D bits.
    always_comb begin
        t      = {r_q, q_q[N-1]};
        ge     = (t >= {1'b0, divisor_q});
        diff   = t[D-1:0] - divisor_q;
        r_step = ge ? diff : t[D-1:0];
        q_step = {q_q[N-2:0], ge};
    end

    always_comb begin
        r_d         = r_q;
        q_d         = q_q;
        divisor_d   = divisor_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        if (load) begin
            divisor_d = divisor;
            r_d       = '0;
            q_d       = dividend;
        end else if (calc) begin
            r_d = r_step;
            q_d = q_step;
        end
        if (last) begin
            quotient_d  = q_step;
            remainder_d = r_step;
        end
        if (dz_load) begin
            quotient_d  = N'(DZ_QUOTIENT);
            remainder_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_a) begin
            r_q         <= '0;
            q_q         <= '0;
            divisor_q   <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            r_q         <= r_d;
            q_q         <= q_d;
            divisor_q   <= divisor_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
        end
    end

    assign quotient_out  = quotient_q;
    assign remainder_out = remainder_q;

endmodule

// File: tb/tb_div16x8_seq.sv
// Self-checking bench for div16x8_seq: expected results are queued when an operation is
// accepted and checked when the DUT enters DONE or DZERO.
module tb_div16x8_seq;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CALC  = 3'd1;
    localparam logic [2:0] S_DONE  = 3'd2;
    localparam logic [2:0] S_DZERO = 3'd3;

    logic        clk = 1'b0;
    logic        reset_a = 1'b1;
    logic        start = 1'b0;
    logic [15:0] dividend = '0;
    logic [7:0]  divisor = '0;
    logic [15:0] quotient_out;
    logic [7:0]  remainder_out;
    logic        done_flag;
    logic        dz_flag;
    logic [2:0]  state_out;

    typedef struct {
        logic [15:0] dvd;
        logic [7:0]  dvs;
        logic [15:0] q;
        logic [7:0]  r;
        bit          dz;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cycle = 0;

    div16x8_seq dut (
        .clk          (clk),
        .reset_a      (reset_a),
        .start        (start),
        .dividend     (dividend),
        .divisor      (divisor),
        .quotient_out (quotient_out),
        .remainder_out(remainder_out),
        .done_flag    (done_flag),
        .dz_flag      (dz_flag),
        .state_out    (state_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    // Result monitor: pops one expectation each time the DUT enters DONE or DZERO.
    initial begin
        exp_t       e;
        logic [2:0] prev_state;
        prev_state = S_IDLE;
        forever begin
            @(posedge clk);
            #1;
            if (!reset_a && ((state_out == S_DONE && prev_state != S_DONE) ||
                             (state_out == S_DZERO && prev_state != S_DZERO))) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_result: q=%h r=%h state=%0d with no op outstanding",
                             quotient_out, remainder_out, state_out);
                end else begin
                    e = sb.pop_front();
                    if (quotient_out !== e.q || remainder_out !== e.r) begin
                        miscompares++;
                        $display("FAIL result %h/%h: got q=%h r=%h, want q=%h r=%h",
                                 e.dvd, e.dvs, quotient_out, remainder_out, e.q, e.r);
                    end
                    vectors++;
                    if (dz_flag !== e.dz || done_flag !== 1'b1) begin
                        miscompares++;
                        $display("FAIL flags %h/%h: got done=%b dz=%b, want done=1 dz=%b",
                                 e.dvd, e.dvs, done_flag, dz_flag, e.dz);
                    end
                    vectors++;
                    if (cycle !== e.cyc) begin
                        miscompares++;
                        $display("FAIL latency %h/%h: done at cycle %0d, want %0d",
                                 e.dvd, e.dvs, cycle, e.cyc);
                    end
                    if (!e.dz) begin
                        vectors++;
                        if (32'(quotient_out) * 32'(e.dvs) + 32'(remainder_out) !== 32'(e.dvd) ||
                            remainder_out >= e.dvs) begin
                            miscompares++;
                            $display("FAIL invariant %h/%h: q=%h r=%h do not reconstruct dividend",
                                     e.dvd, e.dvs, quotient_out, remainder_out);
                        end
                    end
                end
            end
            prev_state = state_out;
        end
    end

    // Waits for an accepting state, applies start, optionally queues the expectation.
    // Called and returns at #1 after a rising edge; acc is the cycle of the accept edge.
    task automatic issue(input logic [15:0] dvd, input logic [7:0] dvs, input bit push,
                         input bit hold, input bit has_exp, input logic [15:0] xq,
                         input logic [7:0] xr, output int acc);
        exp_t e;
        int   guard = 0;
        while (!(state_out == S_IDLE || state_out == S_DONE || state_out == S_DZERO)) begin
            @(posedge clk);
            #1;
            guard++;
            if (guard > 60) begin
                vectors++;
                miscompares++;
                $display("FAIL accept_wait: state stuck at %0d, want 0/2/3", state_out);
                break;
            end
        end
        dividend = dvd;
        divisor  = dvs;
        start    = 1'b1;
        if (push) begin
            e.dvd = dvd;
            e.dvs = dvs;
            e.dz  = (dvs == 8'd0);
            if (has_exp) begin
                e.q = xq;
                e.r = xr;
            end else if (dvs == 8'd0) begin
                e.q = 16'hFFFF;
                e.r = 8'd0;
            end else begin
                e.q = dvd / 16'(dvs);
                e.r = 8'(dvd % 16'(dvs));
            end
            e.cyc = cycle + 1 + (e.dz ? 0 : 16);
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        acc      = cycle;
        dividend = 16'($urandom);
        divisor  = 8'($urandom);
        if (!hold) start = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while (sb.size() != 0) begin
            @(posedge clk);
            #1;
            guard++;
            if (guard > 60) begin
                vectors++;
                miscompares++;
                $display("FAIL drain: %0d results never produced, want 0", sb.size());
                sb.delete();
                break;
            end
        end
    endtask

    task automatic check_cleared(input string tag);
        vectors++;
        if (quotient_out !== 16'd0 || remainder_out !== 8'd0) begin
            miscompares++;
            $display("FAIL %s_outputs: got q=%h r=%h, want 0 0", tag, quotient_out, remainder_out);
        end
        vectors++;
        if (done_flag !== 1'b0 || dz_flag !== 1'b0 || state_out !== S_IDLE) begin
            miscompares++;
            $display("FAIL %s_status: got done=%b dz=%b state=%0d, want 0 0 0",
                     tag, done_flag, dz_flag, state_out);
        end
    endtask

    task automatic test_reset();
        reset_a = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_cleared("reset");
        reset_a = 1'b0;
    endtask

    task automatic test_directed();
        int acc;
        issue(16'hFFFF, 8'hFF, 1'b1, 1'b0, 1'b1, 16'h0101, 8'h00, acc);
        drain();
        issue(16'd1000, 8'd7, 1'b1, 1'b0, 1'b1, 16'h008E, 8'd6, acc);
        drain();
        issue(16'd5, 8'd10, 1'b1, 1'b0, 1'b1, 16'd0, 8'd5, acc);
        drain();
        issue(16'hFFFF, 8'h80, 1'b1, 1'b0, 1'b1, 16'h01FF, 8'h7F, acc);
        drain();
    endtask

    task automatic test_div_zero();
        int acc;
        issue(16'h1234, 8'd0, 1'b1, 1'b0, 1'b1, 16'hFFFF, 8'd0, acc);
        drain();
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (quotient_out !== 16'hFFFF || remainder_out !== 8'd0 || dz_flag !== 1'b1 ||
            done_flag !== 1'b1 || state_out !== S_DZERO) begin
            miscompares++;
            $display("FAIL dz_hold: got q=%h r=%h dz=%b done=%b state=%0d, want FFFF 00 1 1 3",
                     quotient_out, remainder_out, dz_flag, done_flag, state_out);
        end
        issue(16'd100, 8'd3, 1'b1, 1'b0, 1'b1, 16'd33, 8'd1, acc);
        vectors++;
        if (dz_flag !== 1'b0 || done_flag !== 1'b0 || state_out !== S_CALC) begin
            miscompares++;
            $display("FAIL dz_clear: got dz=%b done=%b state=%0d, want 0 0 1",
                     dz_flag, done_flag, state_out);
        end
        drain();
    endtask

    task automatic test_start_in_calc();
        int acc;
        issue(16'd100, 8'd3, 1'b1, 1'b0, 1'b1, 16'd33, 8'd1, acc);
        repeat (4) @(posedge clk);
        #1;
        vectors++;
        if (quotient_out !== 16'd33 || remainder_out !== 8'd1 || state_out !== S_CALC) begin
            miscompares++;
            $display("FAIL calc_hold: got q=%h r=%h state=%0d, want 0021 01 1",
                     quotient_out, remainder_out, state_out);
        end
        start    = 1'b1;
        dividend = 16'd50;
        divisor  = 8'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        drain();
        repeat (20) @(posedge clk);
        #1;
        vectors++;
        if (state_out !== S_DONE || quotient_out !== 16'd33 || remainder_out !== 8'd1) begin
            miscompares++;
            $display("FAIL calc_ignore: got state=%0d q=%h r=%h, want 2 0021 01",
                     state_out, quotient_out, remainder_out);
        end
    endtask

    task automatic test_reset_mid_calc();
        int acc;
        issue(16'h4321, 8'h21, 1'b0, 1'b0, 1'b0, 16'd0, 8'd0, acc);
        repeat (8) @(posedge clk);
        #1;
        reset_a = 1'b1;
        @(posedge clk);
        #1;
        reset_a = 1'b0;
        check_cleared("mid_reset");
        issue(16'd200, 8'd9, 1'b1, 1'b0, 1'b1, 16'd22, 8'd2, acc);
        drain();
    endtask

    task automatic test_back_to_back();
        int          acc;
        int          prev_acc = 0;
        logic [7:0]  a, b;
        logic [15:0] dvd;
        for (int i = 0; i < 1000; i++) begin
            if (i % 4 == 0) begin
                // Multiplier round trip: a*b / b must give a remainder 0.
                a   = 8'($urandom_range(0, 255));
                b   = 8'($urandom_range(1, 255));
                dvd = 16'(a) * 16'(b);
                issue(dvd, b, 1'b1, 1'b1, 1'b1, 16'(a), 8'd0, acc);
            end else begin
                dvd = 16'($urandom);
                b   = 8'($urandom_range(1, 255));
                issue(dvd, b, 1'b1, 1'b1, 1'b0, 16'd0, 8'd0, acc);
            end
            if (i > 0) begin
                vectors++;
                if (acc - prev_acc !== 17) begin
                    miscompares++;
                    $display("FAIL b2b_spacing: op %0d accepted %0d cycles after previous, want 17",
                             i, acc - prev_acc);
                end
            end
            prev_acc = acc;
        end
        start = 1'b0;
        drain();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_directed();
        test_div_zero();
        test_start_in_calc();
        test_reset_mid_calc();
        test_back_to_back();
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
